// File: rtl/rv_control_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, ALU/immediate enums and
// the bundled control word.
package rv_control_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_RFN = 2'b10,
    ALUOP_IFN = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic      reg_write;
    imm_src_e  imm_src;
    logic      alu_src;
    logic      mem_write;
    logic      result_src;
    logic      branch;
    logic      jump;
    alu_ctrl_e alu_control;
    logic      illegal;
  } ctrl_t;

endpackage

// File: rtl/rv_control_if.sv
// Instruction-field inputs and decoded control outputs of the main decoder.
interface rv_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       reg_write;
  logic [2:0] imm_src;
  logic       alu_src;
  logic       mem_write;
  logic       result_src;
  logic       branch;
  logic       jump;
  logic [3:0] alu_control;
  logic       illegal_instr;
  logic       illegal_sticky;

  modport master (
    output opcode, funct3, funct7,
    input  reg_write, imm_src, alu_src, mem_write, result_src, branch, jump,
           alu_control, illegal_instr, illegal_sticky
  );

  modport slave (
    input  opcode, funct3, funct7,
    output reg_write, imm_src, alu_src, mem_write, result_src, branch, jump,
           alu_control, illegal_instr, illegal_sticky
  );
endinterface

// File: rtl/rv_alu_decoder.sv
// Second-level decode: alu_op class plus funct3/funct7[5] to the ALU control code.
module rv_alu_decoder
  import rv_control_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_ctrl_e  alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // immediate forms have no subtract; funct7 there is part of the immediate
          3'b000:  alu_control_o = (alu_op_i == ALUOP_RFN && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/rv_control_unit.sv
// RV32I main decoder with sticky illegal-opcode flag.
// CONTROL_REG_OUT_EN: register all decode outputs (1-cycle latency); default combinational.
module rv_control_unit
  import rv_control_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  rv_control_if.slave bus
);

  ctrl_t     dec_d;
  ctrl_t     full_d;
  ctrl_t     ctrl_out;
  alu_op_e   alu_op;
  alu_ctrl_e alu_ctrl;
  logic      sticky_q;

  always_comb begin
    dec_d  = '0;
    alu_op = ALUOP_ADD;
    case (bus.opcode)
      OPC_R: begin
        dec_d.reg_write = 1'b1;
        alu_op          = ALUOP_RFN;
      end
      OPC_I: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        alu_op          = ALUOP_IFN;
      end
      OPC_LOAD: begin
        dec_d.reg_write  = 1'b1;
        dec_d.alu_src    = 1'b1;
        dec_d.result_src = 1'b1;
      end
      OPC_STORE: begin
        dec_d.imm_src   = IMM_S;
        dec_d.alu_src   = 1'b1;
        dec_d.mem_write = 1'b1;
      end
      OPC_BR: begin
        dec_d.imm_src = IMM_B;
        dec_d.branch  = 1'b1;
        alu_op        = ALUOP_SUB;
      end
      OPC_JAL: begin
        dec_d.reg_write = 1'b1;
        dec_d.imm_src   = IMM_J;
        dec_d.jump      = 1'b1;
      end
      OPC_JALR: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        dec_d.jump      = 1'b1;
      end
      OPC_LUI: begin
        dec_d.reg_write = 1'b1;
        dec_d.imm_src   = IMM_U;
        dec_d.alu_src   = 1'b1;
      end
      default: dec_d.illegal = 1'b1;
    endcase
  end

  rv_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .funct7_5_i    (bus.funct7[5]),
    .alu_control_o (alu_ctrl)
  );

  always_comb begin
    full_d             = dec_d;
    full_d.alu_control = alu_ctrl;
  end

`ifdef CONTROL_REG_OUT_EN
  ctrl_t ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= full_d;
  end

  assign ctrl_out = ctrl_q;
`else
  // reset must blank outputs even though nothing here is clocked
  assign ctrl_out = rst_n ? full_d : '0;
`endif

  // tracks the live decode, so it sets on the same edge in both output modes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sticky_q <= 1'b0;
    else if (full_d.illegal) sticky_q <= 1'b1;
  end

  assign bus.reg_write      = ctrl_out.reg_write;
  assign bus.imm_src        = ctrl_out.imm_src;
  assign bus.alu_src        = ctrl_out.alu_src;
  assign bus.mem_write      = ctrl_out.mem_write;
  assign bus.result_src     = ctrl_out.result_src;
  assign bus.branch         = ctrl_out.branch;
  assign bus.jump           = ctrl_out.jump;
  assign bus.alu_control    = ctrl_out.alu_control;
  assign bus.illegal_instr  = ctrl_out.illegal;
  assign bus.illegal_sticky = sticky_q;

endmodule

// File: tb/tb_rv_control_unit.sv
// Directed-vector bench for rv_control_unit; handles both output modes via CONTROL_REG_OUT_EN.
module tb_rv_control_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  rv_control_if bus ();

  rv_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {rw, imm[2:0], as, mw, rs, br, j, alu[3:0], illegal}
  logic [13:0] obs;
  assign obs = {bus.reg_write, bus.imm_src, bus.alu_src, bus.mem_write, bus.result_src,
                bus.branch, bus.jump, bus.alu_control, bus.illegal_instr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    bus.opcode = opc;
    bus.funct3 = f3;
    bus.funct7 = f7;
    #1;
`ifdef CONTROL_REG_OUT_EN
    @(posedge clk);
    #1;
`endif
  endtask

  typedef struct {
    string       tag;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    //                     rw imm as mw rs br j  alu  il
    vecs.push_back('{"R_add",   7'b0110011, 3'b000, 7'b0000000, 14'b1_000_0_0_0_0_0_0000_0});
    vecs.push_back('{"R_sub",   7'b0110011, 3'b000, 7'b0100000, 14'b1_000_0_0_0_0_0_0001_0});
    vecs.push_back('{"R_and",   7'b0110011, 3'b111, 7'b0000000, 14'b1_000_0_0_0_0_0_0010_0});
    vecs.push_back('{"R_sll",   7'b0110011, 3'b001, 7'b0000000, 14'b1_000_0_0_0_0_0_0101_0});
    vecs.push_back('{"R_slt",   7'b0110011, 3'b010, 7'b0000000, 14'b1_000_0_0_0_0_0_1000_0});
    vecs.push_back('{"R_sra",   7'b0110011, 3'b101, 7'b0100000, 14'b1_000_0_0_0_0_0_0111_0});
    vecs.push_back('{"R_or",    7'b0110011, 3'b110, 7'b0000000, 14'b1_000_0_0_0_0_0_0011_0});
    vecs.push_back('{"I_addi",  7'b0010011, 3'b000, 7'b0000000, 14'b1_000_1_0_0_0_0_0000_0});
    vecs.push_back('{"I_add_f7",7'b0010011, 3'b000, 7'b0100000, 14'b1_000_1_0_0_0_0_0000_0});
    vecs.push_back('{"I_srai",  7'b0010011, 3'b101, 7'b0100000, 14'b1_000_1_0_0_0_0_0111_0});
    vecs.push_back('{"I_srli",  7'b0010011, 3'b101, 7'b0000000, 14'b1_000_1_0_0_0_0_0110_0});
    vecs.push_back('{"I_sltiu", 7'b0010011, 3'b011, 7'b0000000, 14'b1_000_1_0_0_0_0_1001_0});
    vecs.push_back('{"I_xori",  7'b0010011, 3'b100, 7'b0000000, 14'b1_000_1_0_0_0_0_0100_0});
    vecs.push_back('{"LW",      7'b0000011, 3'b010, 7'b0000000, 14'b1_000_1_0_1_0_0_0000_0});
    vecs.push_back('{"SW",      7'b0100011, 3'b010, 7'b0100000, 14'b0_001_1_1_0_0_0_0000_0});
    vecs.push_back('{"BEQ",     7'b1100011, 3'b000, 7'b0000000, 14'b0_010_0_0_0_1_0_0001_0});
    vecs.push_back('{"BLTU",    7'b1100011, 3'b110, 7'b0000000, 14'b0_010_0_0_0_1_0_0001_0});
    vecs.push_back('{"JAL",     7'b1101111, 3'b101, 7'b0100000, 14'b1_011_0_0_0_0_1_0000_0});
    vecs.push_back('{"JALR",    7'b1100111, 3'b000, 7'b0000000, 14'b1_000_1_0_0_0_1_0000_0});
    vecs.push_back('{"LUI",     7'b0110111, 3'b111, 7'b0000000, 14'b1_100_1_0_0_0_0_0000_0});
  end

  initial begin
    bus.opcode = 7'b0110011;
    bus.funct3 = 3'b000;
    bus.funct7 = 7'b0000000;

    // reset: legal R-type present but every output held low
    #2;
    chk("rst_outs",   32'(obs), 32'd0);
    chk("rst_sticky", 32'(bus.illegal_sticky), 32'd0);
    @(posedge clk); #1;
    chk("rst_outs_edge", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].opc, vecs[i].f3, vecs[i].f7);
      chk(vecs[i].tag, 32'(obs), 32'(vecs[i].exp));
    end
    chk("sticky_legal", 32'(bus.illegal_sticky), 32'd0);

    // unsupported opcodes
    apply(7'b0010111, 3'b000, 7'b0000000);
    chk("AUIPC", 32'(obs), 32'd1);
    apply(7'b1111111, 3'b000, 7'b0000000);
    chk("ill_ff", 32'(obs), 32'd1);
    @(posedge clk); #1;
    chk("sticky_set", 32'(bus.illegal_sticky), 32'd1);
    apply(7'b0110011, 3'b000, 7'b0100000);
    @(posedge clk); #1;
    chk("post_ill_sub", 32'(obs), 32'(14'b1_000_0_0_0_0_0_0001_0));
    chk("sticky_hold",  32'(bus.illegal_sticky), 32'd1);

    // async reset pulse clears sticky mid-cycle
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_outs",   32'(obs), 32'd0);
    chk("rst2_sticky", 32'(bus.illegal_sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(7'b0110011, 3'b111, 7'b0000000);
    chk("post_rst_and", 32'(obs), 32'(14'b1_000_0_0_0_0_0_0010_0));
    @(posedge clk); #1;
    chk("post_rst_sticky", 32'(bus.illegal_sticky), 32'd0);

`ifdef CONTROL_REG_OUT_EN
    // output lags the input by one edge
    @(negedge clk);
    bus.opcode = 7'b1101111;
    #1;
    chk("lat_old", 32'(obs), 32'(14'b1_000_0_0_0_0_0_0010_0));
    @(posedge clk); #1;
    chk("lat_new", 32'(obs), 32'(14'b1_011_0_0_0_0_1_0000_0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
